// File: rtl/ft_cmd_parser.sv
// FT600 command parser: decodes write/read frames from the RX FIFO into register bus
// strobes and returns read responses. Define FT_CMD_TIMEOUT_EN to abort stalled frames.
module ft_cmd_parser #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_en,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_en,
  input  logic                  tx_full,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_wr,
  output logic                  bus_rd,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [7:0]            err_cnt
);

  localparam logic [7:0]            SYNC     = 8'hA5;
  localparam logic [7:0]            OP_WR    = 8'h01;
  localparam logic [7:0]            OP_RD    = 8'h02;
  localparam logic [DATA_WIDTH-1:0] RESP_HDR_W = DATA_WIDTH'(16'h5A02);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, RD_WAIT, RESP_HDR, RESP_ADDR, RESP_DATA
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("ft_cmd_parser: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                  state, state_d;
  logic                    op_wr;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   rx_word;
  logic [1:0]              rx_be;
  logic                    be_bad, hdr_ok, tmo_hit;
  logic                    err_inc, op_ld, addr_ld, wdata_ld, rdata_ld, wr_d, rd_d;

  assign rx_word = rx_data[DATA_WIDTH-1:0];
  assign rx_be   = rx_data[DATA_WIDTH+1:DATA_WIDTH];
  assign be_bad  = (rx_be != 2'b11);
  assign hdr_ok  = (rx_word[15:8] == SYNC) && (rx_word[7:0] == OP_WR || rx_word[7:0] == OP_RD);

`ifdef FT_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_wait;

  // Counts only idle cycles inside a frame; any consumed word or leaving ADDR/DATA clears it.
  assign tmo_wait = (state == ADDR || state == DATA) && !rx_valid;
  assign tmo_hit  = tmo_wait && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   tmo_cnt <= '0;
    else if (!tmo_wait || tmo_hit) tmo_cnt <= '0;
    else                          tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    rx_en    = rst_n && rx_valid && (state == IDLE || state == ADDR || state == DATA);
    tx_en    = (state == RESP_HDR || state == RESP_ADDR || state == RESP_DATA) && !tx_full;
    tx_data  = '0;
    err_inc  = 1'b0;
    op_ld    = 1'b0;
    addr_ld  = 1'b0;
    wdata_ld = 1'b0;
    rdata_ld = 1'b0;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    unique case (state)
      IDLE: if (rx_valid) begin
        if (be_bad || !hdr_ok) err_inc = 1'b1;
        else begin
          op_ld   = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: if (rx_valid) begin
        if (be_bad) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          addr_ld = 1'b1;
          if (op_wr) state_d = DATA;
          else begin
            rd_d    = 1'b1;
            state_d = RD_WAIT;
          end
        end
      end else if (tmo_hit) begin
        err_inc = 1'b1;
        state_d = IDLE;
      end
      DATA: if (rx_valid) begin
        state_d = IDLE;
        if (be_bad) err_inc = 1'b1;
        else begin
          wdata_ld = 1'b1;
          wr_d     = 1'b1;
        end
      end else if (tmo_hit) begin
        err_inc = 1'b1;
        state_d = IDLE;
      end
      // First RD_WAIT cycle carries bus_rd; read data lands in the second.
      RD_WAIT: if (!bus_rd) begin
        rdata_ld = 1'b1;
        state_d  = RESP_HDR;
      end
      RESP_HDR: begin
        tx_data = RESP_HDR_W;
        if (tx_en) state_d = RESP_ADDR;
      end
      RESP_ADDR: begin
        tx_data = bus_addr;
        if (tx_en) state_d = RESP_DATA;
      end
      RESP_DATA: begin
        tx_data = rdata_q;
        if (tx_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wr    <= 1'b0;
      bus_rd    <= 1'b0;
      rdata_q   <= '0;
      err_cnt   <= '0;
    end else begin
      state  <= state_d;
      bus_wr <= wr_d;
      bus_rd <= rd_d;
      if (op_ld)    op_wr     <= (rx_word[7:0] == OP_WR);
      if (addr_ld)  bus_addr  <= rx_word;
      if (wdata_ld) bus_wdata <= rx_word;
      if (rdata_ld) rdata_q   <= bus_rdata;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ft_cmd_parser.sv
// Bench for ft_cmd_parser: directed vector table, stall/reset/timeout sequences, and a
// randomized word stream checked against a frame-level reference parser.
module tb_ft_cmd_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_en;
  logic [15:0] tx_data;
  logic        tx_en;
  logic        tx_full = 1'b0;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_wr, bus_rd;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int full_pct = 0;
  bit hold_full = 1'b0;

  logic [31:0] mon_wr[$];
  logic [15:0] mon_rd[$];
  logic [15:0] mon_tx[$];
  logic [31:0] m_wr[$];
  logic [15:0] m_tx[$];
  int          m_err;

  ft_cmd_parser #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_en(rx_en),
    .tx_data(tx_data), .tx_en(tx_en), .tx_full(tx_full), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_rdata(bus_rdata),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_fn(input logic [15:0] a);
    return (a == 16'h0020) ? 16'h1234 : (a ^ 16'hC3A5);
  endfunction

  // Register slave: data is valid exactly one cycle after bus_rd, garbage otherwise.
  always @(posedge clk) bus_rdata <= bus_rd ? rd_fn(bus_addr) : 16'($urandom);

  initial forever begin
    @(posedge clk); #1;
    if (!hold_full) tx_full = (full_pct != 0) && ($urandom_range(99) < full_pct);
  end

  always @(negedge clk) if (rst_n) begin
    if (bus_wr) mon_wr.push_back({bus_addr, bus_wdata});
    if (bus_rd) mon_rd.push_back(bus_addr);
    if (tx_en)  mon_tx.push_back(tx_data);
    if (bus_wr && bus_rd) begin
      n_cmp++; n_fail++;
      $display("FAIL wr_rd_overlap: both strobes high at %0t, required at most one", $time);
    end
    if (tx_en && tx_full) begin
      n_cmp++; n_fail++;
      $display("FAIL tx_en_while_full: tx_en=1 with tx_full=1 at %0t, required 0", $time);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_mon();
    mon_wr.delete(); mon_rd.delete(); mon_tx.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_valid = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic push_word(input logic [17:0] w);
    bit got = 1'b0;
    rx_data = w; rx_valid = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk); got = rx_en;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: word %h not consumed, required consumption", w);
    end
  endtask

  function automatic logic [17:0] okw(input logic [15:0] d);
    return {2'b11, d};
  endfunction

  function automatic logic [15:0] rnd16();
    logic [15:0] v = 16'($urandom);
    if (v[15:8] == 8'hA5) v[15:8] = 8'h5A;
    return v;
  endfunction

  // Reference parser: walks the stream frame by frame rather than cycle by cycle.
  task automatic model_run(input logic [17:0] ws[$]);
    int i = 0;
    int n = ws.size();
    m_wr.delete(); m_tx.delete(); m_err = 0;
    while (i < n) begin
      logic [17:0] h = ws[i];
      logic        is_wr;
      if (h[17:16] != 2'b11 || h[15:8] != 8'hA5 || (h[7:0] != 8'h01 && h[7:0] != 8'h02)) begin
        m_err++; i++; continue;
      end
      is_wr = (h[7:0] == 8'h01);
      if (i + 1 >= n) break;
      if (ws[i+1][17:16] != 2'b11) begin m_err++; i += 2; continue; end
      if (!is_wr) begin
        m_tx.push_back(16'h5A02);
        m_tx.push_back(ws[i+1][15:0]);
        m_tx.push_back(rd_fn(ws[i+1][15:0]));
        i += 2; continue;
      end
      if (i + 2 >= n) break;
      if (ws[i+2][17:16] != 2'b11) begin m_err++; i += 3; continue; end
      m_wr.push_back({ws[i+1][15:0], ws[i+2][15:0]});
      i += 3;
    end
    if (m_err > 255) m_err = 255;
  endtask

  typedef struct packed {
    logic [3:0]        nw;
    logic [0:5][17:0]  w;
    logic [1:0]        nwr;
    logic [31:0]       wr;
    logic [1:0]        ntx;
    logic [0:2][15:0]  tx;
    logic [7:0]        err;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [17:0] ws[$];

    vt[0] = '{nw: 4'd3, w: '{okw(16'hA501), okw(16'h0010), okw(16'hBEEF), 18'h0, 18'h0, 18'h0},
              nwr: 2'd1, wr: 32'h0010BEEF, ntx: 2'd0, tx: '{16'h0, 16'h0, 16'h0}, err: 8'd0};
    vt[1] = '{nw: 4'd2, w: '{okw(16'hA502), okw(16'h0020), 18'h0, 18'h0, 18'h0, 18'h0},
              nwr: 2'd0, wr: 32'h0, ntx: 2'd3, tx: '{16'h5A02, 16'h0020, 16'h1234}, err: 8'd0};
    vt[2] = '{nw: 4'd4, w: '{okw(16'h1234), {2'b01, 16'hA501}, okw(16'hA502), okw(16'h0030), 18'h0, 18'h0},
              nwr: 2'd0, wr: 32'h0, ntx: 2'd3, tx: '{16'h5A02, 16'h0030, 16'hC395}, err: 8'd2};
    vt[3] = '{nw: 4'd5, w: '{okw(16'hA501), {2'b10, 16'h0040}, okw(16'hA501), okw(16'h0041), okw(16'h0042), 18'h0},
              nwr: 2'd1, wr: 32'h00410042, ntx: 2'd0, tx: '{16'h0, 16'h0, 16'h0}, err: 8'd1};
    vt[4] = '{nw: 4'd4, w: '{okw(16'hA503), okw(16'hA501), okw(16'h0050), {2'b00, 16'h1111}, 18'h0, 18'h0},
              nwr: 2'd0, wr: 32'h0, ntx: 2'd0, tx: '{16'h0, 16'h0, 16'h0}, err: 8'd2};

    // Reset state, with rx_valid already asserted
    rst_n = 1'b0; rx_valid = 1'b1; rx_data = okw(16'hA501);
    @(negedge clk);
    chk("rst_rx_en", rx_en, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_strobes", {bus_wr, bus_rd}, 0);
    chk("rst_addr_wdata", {bus_addr, bus_wdata}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rx_valid = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      do_reset(); clr_mon();
      for (int j = 0; j < int'(vt[v].nw); j++) push_word(vt[v].w[j]);
      cyc(20);
      chk($sformatf("vec%0d_nwr", v), mon_wr.size(), vt[v].nwr);
      if (vt[v].nwr != 0 && mon_wr.size() != 0) chk($sformatf("vec%0d_wr", v), mon_wr[0], vt[v].wr);
      chk($sformatf("vec%0d_nrd", v), mon_rd.size(), (vt[v].ntx != 0) ? 1 : 0);
      chk($sformatf("vec%0d_ntx", v), mon_tx.size(), vt[v].ntx);
      for (int k = 0; k < int'(vt[v].ntx) && k < mon_tx.size(); k++)
        chk($sformatf("vec%0d_tx%0d", v, k), mon_tx[k], vt[v].tx[k]);
      chk($sformatf("vec%0d_err", v), err_cnt, vt[v].err);
    end

    // Response stalled by tx_full for 5 cycles while in RESP_ADDR
    do_reset(); clr_mon();
    push_word(okw(16'hA502)); push_word(okw(16'h0020));
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin @(negedge clk); seen = tx_en; end
      chk("stall_hdr_seen", seen, 1);
    end
    @(posedge clk); #1;
    hold_full = 1'b1; tx_full = 1'b1;
    repeat (5) begin
      @(negedge clk); chk("stall_tx_en", tx_en, 0);
      @(posedge clk); #1;
    end
    hold_full = 1'b0; tx_full = 1'b0;
    cyc(20);
    chk("stall_ntx", mon_tx.size(), 3);
    if (mon_tx.size() == 3) begin
      chk("stall_tx0", mon_tx[0], 16'h5A02);
      chk("stall_tx1", mon_tx[1], 16'h0020);
      chk("stall_tx2", mon_tx[2], 16'h1234);
    end

    // Error counter saturation, then reset during a stalled RESP_HDR
    do_reset(); clr_mon();
    for (int k = 0; k < 300; k++) push_word(okw(16'h1200 + 16'(k)));
    cyc(1);
    chk("sat_err_cnt", err_cnt, 8'hFF);
    hold_full = 1'b1; tx_full = 1'b1;
    push_word(okw(16'hA502)); push_word(okw(16'h0060));
    cyc(6);
    chk("hdr_stall_ntx", mon_tx.size(), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rx_tx_en", {rx_en, tx_en}, 0);
    chk("midrst_strobes", {bus_wr, bus_rd}, 0);
    chk("midrst_addr_wdata", {bus_addr, bus_wdata}, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    hold_full = 1'b0; tx_full = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(20);
    chk("postrst_ntx", mon_tx.size(), 0);
    chk("postrst_nrd", mon_rd.size(), 1);

`ifdef FT_CMD_TIMEOUT_EN
    do_reset(); clr_mon();
    push_word(okw(16'hA501));
    cyc(12);
    chk("tmo_err_cnt", err_cnt, 1);
    push_word(okw(16'hA501)); push_word(okw(16'h0070)); push_word(okw(16'hABCD));
    cyc(10);
    chk("tmo_nwr", mon_wr.size(), 1);
    if (mon_wr.size() == 1) chk("tmo_wr", mon_wr[0], 32'h0070ABCD);
    chk("tmo_err_after", err_cnt, 1);
`endif

    // Randomized stream against the reference parser
    do_reset(); clr_mon();
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(4))
        0: begin ws.push_back(okw(16'hA501)); ws.push_back(okw(rnd16())); ws.push_back(okw(rnd16())); end
        1: begin ws.push_back(okw(16'hA502)); ws.push_back(okw(rnd16())); end
        2: ws.push_back({2'($urandom), rnd16()});
        3: begin
          ws.push_back({2'($urandom_range(3)), 16'hA501});
          ws.push_back({2'($urandom_range(3)), rnd16()});
          ws.push_back({2'($urandom_range(3)), rnd16()});
        end
        default: begin ws.push_back({2'($urandom_range(3)), 16'hA502}); ws.push_back(okw(rnd16())); end
      endcase
    end
    model_run(ws);
    full_pct = 25;
    foreach (ws[i]) begin
      push_word(ws[i]);
      cyc($urandom_range(2));
    end
    cyc(80);
    full_pct = 0;
    cyc(2);
    chk("rnd_nwr", mon_wr.size(), m_wr.size());
    for (int k = 0; k < m_wr.size() && k < mon_wr.size(); k++) chk($sformatf("rnd_wr%0d", k), mon_wr[k], m_wr[k]);
    chk("rnd_nrd", mon_rd.size(), m_tx.size() / 3);
    chk("rnd_ntx", mon_tx.size(), m_tx.size());
    for (int k = 0; k < m_tx.size() && k < mon_tx.size(); k++) chk($sformatf("rnd_tx%0d", k), mon_tx[k], m_tx[k]);
    chk("rnd_err_cnt", err_cnt, 8'(m_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ft_cmd_parser.md
FT_CMD_PARSER -- requirements
Module: ft_cmd_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the FT600 word width (fixed at 16 for this block).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, the inter-word idle limit used when FT_CMD_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk  in  1  single clock, same domain as the ft600 port side.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  in  18  {byte_enable[1:0], data[15:0]} from the ft600 RX FIFO (fwft).
REQ-006 SHALL have port rx_valid  in  1  rx_data valid.
REQ-007 SHALL have port rx_en  out  1  consume the current rx word.
REQ-008 SHALL have port tx_data  out  16  response word to the ft600 TX FIFO.
REQ-009 SHALL have port tx_en  out  1  push tx_data.
REQ-010 SHALL have port tx_full  in  1  TX FIFO full.
REQ-011 SHALL have port bus_addr  out  16  register address.
REQ-012 SHALL have port bus_wdata  out  16  write data.
REQ-013 SHALL have port bus_wr  out  1  one-cycle write strobe.
REQ-014 SHALL have port bus_rd  out  1  one-cycle read strobe.
REQ-015 SHALL have port bus_rdata  in  16  read data, valid exactly 1 cycle after bus_rd.
REQ-016 SHALL have port err_cnt  out  8  saturating protocol-error count.

Function
REQ-017 Frame format SHALL be: header {8'hA5, opcode}, then address word, then a data word for write only; opcode 8'h01 = write, 8'h02 = read.
REQ-018 States SHALL be IDLE, ADDR, DATA, RD_WAIT, RESP_HDR, RESP_ADDR, RESP_DATA.
REQ-019 rx_en SHALL equal rx_valid AND state in {IDLE, ADDR, DATA} (combinational, 0 latency); each word is consumed in exactly one cycle.
REQ-020 IDLE: a consumed valid header with opcode 01/02 SHALL latch the opcode and go to ADDR; any other word SHALL be discarded, increment err_cnt, and stay in IDLE.
REQ-021 ADDR: the consumed word SHALL latch into bus_addr; next state is DATA for a write, or RD_WAIT with bus_rd=1 in the following cycle for a read.
REQ-022 DATA: the consumed word SHALL latch into bus_wdata; bus_wr SHALL pulse for exactly 1 cycle in the next cycle, then the FSM returns to IDLE.
REQ-023 RD_WAIT: bus_rdata SHALL be captured 1 cycle after bus_rd, then the FSM goes to RESP_HDR.
REQ-024 RESP_HDR/RESP_ADDR/RESP_DATA SHALL emit 16'h5A02, the address, and the captured read data in that order; tx_en = state in RESP_* AND !tx_full; the FSM advances only on a cycle with tx_en=1; after RESP_DATA it returns to IDLE.
REQ-025 While tx_full=1 the FSM SHALL hold its RESP_* state with tx_data stable; no response word is dropped or duplicated.
REQ-026 A consumed word whose byte_enable is not 2'b11, in any receive state, SHALL be discarded, increment err_cnt, and return the FSM to IDLE without issuing a bus strobe.
REQ-027 err_cnt SHALL saturate at 8'hFF; a simultaneous error and saturation SHALL hold 8'hFF.
REQ-028 rx_en SHALL be 0 throughout RD_WAIT and RESP_*, so a back-to-back frame waits in the FIFO.
REQ-029 bus_wr and bus_rd SHALL never both be 1 in the same cycle.

Reset
REQ-030 On rst_n=0 the block SHALL immediately enter IDLE with rx_en=0, tx_en=0, bus_wr=0, bus_rd=0, bus_addr=0, bus_wdata=0, err_cnt=0, and the timeout counter cleared.
REQ-031 Reset mid-frame or mid-response SHALL abandon the frame with no further bus strobe or tx word; after reset release, the first consumed word is treated as a header.

Configuration
REQ-032 With FT_CMD_TIMEOUT_EN defined, a counter SHALL clear on each consumed word and count while state is ADDR or DATA with rx_valid=0; on reaching TIMEOUT_CYCLES it SHALL return the FSM to IDLE and increment err_cnt.
REQ-033 Without FT_CMD_TIMEOUT_EN, no timeout logic SHALL exist and ADDR/DATA SHALL wait indefinitely.

Verification
REQ-034 Write frame A501, 0010, BEEF (be=11) -> one bus_wr pulse with bus_addr=0010, bus_wdata=BEEF; no tx_en; err_cnt=0.
REQ-035 Read frame A502, 0020 with bus_rdata=1234 -> one bus_rd pulse; tx sequence 5A02, 0020, 1234.
REQ-036 Read response with tx_full held 1 for 5 cycles before RESP_ADDR -> tx_en=0 during those cycles; sequence still exactly 5A02, 0020, 1234.
REQ-037 Words 1234, then A501 with be=01, then A502, 0030 -> err_cnt=2; one correct read response for 0030.
REQ-038 300 bad headers -> err_cnt=FF; assert rst_n=0 during RESP_HDR -> all outputs 0 and no further tx words.
REQ-039 (FT_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=8) A501 then no data for 8 cycles -> return to IDLE, err_cnt=1; a following complete frame executes normally.
